// File: rtl/mbist_pkg.sv
// Shared types for the MBIST March C- sequencing counter.
package mbist_pkg;

  typedef enum logic [2:0] {
    M0_UP_W0   = 3'd0,
    M1_UP_R0W1 = 3'd1,
    M2_UP_R1W0 = 3'd2,
    M3_DN_R0W1 = 3'd3,
    M4_DN_R1W0 = 3'd4,
    M5_DN_R0   = 3'd5
  } march_phase_t;

  typedef enum logic {
    OP_FIRST  = 1'b0,
    OP_SECOND = 1'b1
  } op_slot_t;

  localparam logic [2:0] LAST_PHASE = 3'd5;

  // Unused encodings 6/7 fall back to the first element.
  function automatic march_phase_t next_phase(input march_phase_t p);
    if (p >= LAST_PHASE) begin
      return M0_UP_W0;
    end else begin
      return march_phase_t'(p + 3'd1);
    end
  endfunction

endpackage

// File: rtl/mbist_march_decode.sv
// Combinational decode of (march element, op slot) into operation attributes.
module mbist_march_decode
  import mbist_pkg::*;
(
  input  march_phase_t phase,
  input  logic         op,
  output logic         is_write,
  output logic         data_bit,
  output logic         dir_down,
  output logic         last_op
);

  // Decode table of the six March C- elements.
  always_comb begin
    is_write = 1'b0;
    data_bit = 1'b0;
    dir_down = 1'b0;
    last_op  = 1'b1;
    case (phase)
      M0_UP_W0: begin
        is_write = 1'b1;
        data_bit = 1'b0;
        dir_down = 1'b0;
        last_op  = 1'b1;
      end
      M1_UP_R0W1: begin
        is_write = op;
        data_bit = op;
        dir_down = 1'b0;
        last_op  = op;
      end
      M2_UP_R1W0: begin
        is_write = op;
        data_bit = ~op;
        dir_down = 1'b0;
        last_op  = op;
      end
      M3_DN_R0W1: begin
        is_write = op;
        data_bit = op;
        dir_down = 1'b1;
        last_op  = op;
      end
      M4_DN_R1W0: begin
        is_write = op;
        data_bit = ~op;
        dir_down = 1'b1;
        last_op  = op;
      end
      M5_DN_R0: begin
        is_write = 1'b0;
        data_bit = 1'b0;
        dir_down = 1'b1;
        last_op  = 1'b1;
      end
      default: begin
        is_write = 1'b0;
        data_bit = 1'b0;
        dir_down = 1'b0;
        last_op  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mbist_march_counter.sv
// March C- sequencing counter: drives address, data and strobes to the memory under test.
// Optional MBIST_CHECKERBOARD_EN selects a checkerboard data background instead of solid.
module mbist_march_counter
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] exp_data,
  output logic              wr_en,
  output logic              rd_en,
  output logic [2:0]        phase,
  output logic              cout
);

  localparam logic [ADDR_W-1:0] IDX_MAX = {ADDR_W{1'b1}};

  march_phase_t      phase_q, phase_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  op_slot_t          op_q, op_d;

  logic is_write_s;
  logic data_bit_s;
  logic dir_down_s;
  logic last_op_s;
  logic en_act_s;
  logic [DATA_W-1:0] data_s;

`ifdef MBIST_CHECKERBOARD_EN
  function automatic logic [DATA_W-1:0] bg_pattern(input logic odd_addr);
    logic [DATA_W-1:0] p;
    p = {DATA_W{1'b0}};
    for (int i = 0; i < DATA_W; i++) begin
      p[i] = (i % 2 == 1) ^ odd_addr;
    end
    return p;
  endfunction
`endif

  mbist_march_decode u_decode (
    .phase    (phase_q),
    .op       (op_q),
    .is_write (is_write_s),
    .data_bit (data_bit_s),
    .dir_down (dir_down_s),
    .last_op  (last_op_s)
  );

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= M0_UP_W0;
      idx_q   <= {ADDR_W{1'b0}};
      op_q    <= OP_FIRST;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
    end
  end

  // Next-state: load clears, enable walks op -> index -> element.
  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    op_d    = op_q;
    if (ld) begin
      phase_d = M0_UP_W0;
      idx_d   = {ADDR_W{1'b0}};
      op_d    = OP_FIRST;
    end else if (en) begin
      if (!last_op_s) begin
        op_d = OP_SECOND;
      end else if (idx_q != IDX_MAX) begin
        op_d  = OP_FIRST;
        idx_d = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        op_d    = OP_FIRST;
        idx_d   = {ADDR_W{1'b0}};
        phase_d = next_phase(phase_q);
      end
    end else begin
      phase_d = phase_q;
      idx_d   = idx_q;
      op_d    = op_q;
    end
  end

  // Strobes are held low while reset is asserted even if en is high.
  assign en_act_s = en & rst_n;

  // Down elements mirror the index: (N-1) - idx is the bitwise inverse.
  assign addr = dir_down_s ? ~idx_q : idx_q;

`ifdef MBIST_CHECKERBOARD_EN
  assign data_s = {DATA_W{data_bit_s}} ^ bg_pattern(addr[0]);
`else
  assign data_s = {DATA_W{data_bit_s}};
`endif

  assign wdata    = is_write_s ? data_s : {DATA_W{1'b0}};
  assign exp_data = is_write_s ? {DATA_W{1'b0}} : data_s;
  assign wr_en    = en_act_s & is_write_s;
  assign rd_en    = en_act_s & ~is_write_s;
  assign phase    = phase_q;
  assign cout     = en_act_s & (phase_q == M5_DN_R0) & (idx_q == IDX_MAX);

endmodule
